// File: rtl/obstacle_gen_if.sv
// Obstacle generator bus: game-mode control into the block and the packed
// obstacle slot rectangles out of it.
//   gamemode   : 2-bit game state driven by the game controller
//   obstacle_x : 10 slots x {left[9:0], right[9:0]}
//   obstacle_y : 10 slots x {top[8:0], bottom[8:0]}
// master = game controller / renderer side, slave = obstacle_gen.
interface obstacle_gen_if;
    logic [1:0]   gamemode;
    logic [199:0] obstacle_x;
    logic [179:0] obstacle_y;

    modport master (
        output gamemode,
        input  obstacle_x,
        input  obstacle_y
    );

    modport slave (
        input  gamemode,
        output obstacle_x,
        output obstacle_y
    );
endinterface

// File: rtl/obstacle_gen.sv
// Obstacle generator for a side-scrolling game. Up to ten rectangular
// obstacles enter at the right screen edge, scroll left by SPEED pixels every
// TICK_DIV clocks and disappear at the left edge. A new obstacle spawns at most
// once every SPAWN_GAP+1 steps; its height and ceiling/floor placement come
// from a 16-bit LFSR.
//   clk   : system clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : obstacle_gen_if slave (gamemode in, obstacle_x/obstacle_y out)
module obstacle_gen #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int OBS_W     = 32,
    parameter int TICK_DIV  = 1000000,
    parameter int SPEED     = 4,
    parameter int SPAWN_GAP = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    obstacle_gen_if.slave bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(SPAWN_GAP);
    localparam logic [9:0]  SPEED_X   = 10'(SPEED);
    localparam logic [9:0]  SPAWN_L   = 10'(SCREEN_W - OBS_W);
    localparam logic [9:0]  SPAWN_R   = 10'(SCREEN_W - 1);
    localparam logic [8:0]  SCR_H     = 9'(SCREEN_H);
    localparam logic [8:0]  SCR_H_M1  = 9'(SCREEN_H - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11; a nonzero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Move one surviving slot left; left edge saturates at column 0.
    function automatic logic [19:0] move_x(input logic [19:0] x);
        logic [9:0] left_v;
        left_v = (x[19:10] > SPEED_X) ? (x[19:10] - SPEED_X) : 10'd0;
        move_x = {left_v, x[9:0] - SPEED_X};
    endfunction

    logic [199:0]      x_r, x_n;
    logic [179:0]      y_r, y_n;
    logic [TICK_W-1:0] tick_r, tick_n;
    logic [GAP_W-1:0]  gap_r, gap_n;
    logic [15:0]       lfsr_r, lfsr_n;
    logic              step_s;
    logic              spawn_en_s;
    logic              spawn_done_s;
    logic [8:0]        h_s;
    logic [17:0]       spawn_y_s;

    assign step_s = (bus.gamemode == 2'b01) && (tick_r == TICK_LAST);
    assign h_s    = 9'd40 + {3'b000, lfsr_r[5:0]};
    // lfsr[6] picks a floor obstacle (1) or a ceiling obstacle (0).
    assign spawn_y_s = lfsr_r[6] ? {SCR_H - h_s, SCR_H_M1} : {9'd0, h_s - 9'd1};

    // Next-state logic: mode handling, tick/gap counters, slot movement, spawn.
    always_comb begin
        x_n          = x_r;
        y_n          = y_r;
        tick_n       = tick_r;
        gap_n        = gap_r;
        lfsr_n       = lfsr_r;
        spawn_en_s   = 1'b0;
        spawn_done_s = 1'b0;
        case (bus.gamemode)
            2'b00: begin
                x_n    = 200'd0;
                y_n    = 180'd0;
                tick_n = '0;
                gap_n  = '0;
                lfsr_n = LFSR_SEED;
            end
            2'b01: begin
                lfsr_n = lfsr_next(lfsr_r);
                if (step_s) begin
                    tick_n = '0;
                    // Move or retire every slot that was active before this step.
                    for (int i = 0; i < 10; i++) begin
                        if (x_r[20*i +: 10] == 10'd0) begin
                            x_n[20*i +: 20] = x_r[20*i +: 20];
                        end else if (x_r[20*i +: 10] <= SPEED_X) begin
                            x_n[20*i +: 20] = 20'd0;
                            y_n[18*i +: 18] = 18'd0;
                        end else begin
                            x_n[20*i +: 20] = move_x(x_r[20*i +: 20]);
                        end
                    end
                    if (gap_r == GAP_MAX) begin
                        spawn_en_s = 1'b1;
                    end else begin
                        gap_n = gap_r + GAP_W'(1);
                    end
                    // Free slots are judged on pre-step state, so a slot retiring
                    // this step cannot be reused until the next step.
                    for (int i = 0; i < 10; i++) begin
                        if (spawn_en_s && !spawn_done_s && (x_r[20*i +: 10] == 10'd0)) begin
                            x_n[20*i +: 20] = {SPAWN_L, SPAWN_R};
                            y_n[18*i +: 18] = spawn_y_s;
                            spawn_done_s    = 1'b1;
                        end else begin
                            spawn_done_s    = spawn_done_s;
                        end
                    end
                    // With no free slot the gap counter stays saturated.
                    if (spawn_done_s) begin
                        gap_n = '0;
                    end else begin
                        gap_n = gap_n;
                    end
                end else begin
                    tick_n = tick_r + TICK_W'(1);
                end
            end
            default: begin
                x_n = x_r;
            end
        endcase
    end

    // State registers; outputs come straight from x_r/y_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= 200'd0;
            y_r    <= 180'd0;
            tick_r <= '0;
            gap_r  <= '0;
            lfsr_r <= LFSR_SEED;
        end else begin
            x_r    <= x_n;
            y_r    <= y_n;
            tick_r <= tick_n;
            gap_r  <= gap_n;
            lfsr_r <= lfsr_n;
        end
    end

    assign bus.obstacle_x = x_r;
    assign bus.obstacle_y = y_r;

endmodule

// File: tb/tb_obstacle_gen.sv
// Randomised scoreboard bench for obstacle_gen with TICK_DIV=4, SPEED=4,
// SPAWN_GAP=2. A slot-list reference model predicts the outputs after every
// clock edge; a monitor compares them on the falling edge.
module tb_obstacle_gen;

    localparam int TD  = 4;
    localparam int SP  = 4;
    localparam int GAP = 2;

    typedef struct {
        logic [199:0] x;
        logic [179:0] y;
        int           dir;   // 0 none, 1 slot0 x == {608,639}, 2 all zero
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    obstacle_gen_if bus ();

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state
    int m_left[10], m_right[10], m_top[10], m_bot[10];
    int m_tick, m_gap, m_lfsr;

    obstacle_gen #(
        .SCREEN_W(640), .SCREEN_H(480), .OBS_W(32),
        .TICK_DIV(TD), .SPEED(SP), .SPAWN_GAP(GAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_left[i] = 0; m_right[i] = 0; m_top[i] = 0; m_bot[i] = 0;
        end
        m_tick = 0;
        m_gap  = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic model_edge(input logic [1:0] m);
        int free;
        int h;
        int fb;
        if (m == 2'b00) begin
            model_reset();
        end else if (m == 2'b01) begin
            if (m_tick == TD - 1) begin
                m_tick = 0;
                free = -1;
                for (int i = 0; i < 10; i++)
                    if (m_right[i] == 0 && free < 0) free = i;
                for (int i = 0; i < 10; i++) begin
                    if (m_right[i] != 0) begin
                        if (m_right[i] <= SP) begin
                            m_left[i] = 0; m_right[i] = 0; m_top[i] = 0; m_bot[i] = 0;
                        end else begin
                            m_right[i] = m_right[i] - SP;
                            m_left[i]  = (m_left[i] - SP < 0) ? 0 : m_left[i] - SP;
                        end
                    end
                end
                if (m_gap == GAP) begin
                    if (free >= 0) begin
                        h = 40 + (m_lfsr % 64);
                        m_left[free]  = 640 - 32;
                        m_right[free] = 639;
                        if (((m_lfsr / 64) % 2) == 1) begin
                            m_top[free] = 480 - h; m_bot[free] = 479;
                        end else begin
                            m_top[free] = 0; m_bot[free] = h - 1;
                        end
                        m_gap = 0;
                    end
                end else begin
                    m_gap = m_gap + 1;
                end
            end else begin
                m_tick = m_tick + 1;
            end
            fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            e.x[20*i +: 20] = {10'(m_left[i]), 10'(m_right[i])};
            e.y[18*i +: 18] = {9'(m_top[i]), 9'(m_bot[i])};
        end
        e.dir = 0;
        exp_q.push_back(e);
    endtask

    // One clock: model the edge with the inputs it sees, then set next inputs.
    task automatic tick(input logic [1:0] nm, input logic nr);
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge(bus.gamemode);
        else       model_reset();
        push_expected();
        #1;
        bus.gamemode = nm;
        rst_n        = nr;
    endtask

    task automatic run(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) tick(m, 1'b1);
    endtask

    // Called just after a rising edge: pulse reset mid-cycle for a few clocks.
    task automatic apply_reset(input logic [1:0] m_after);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        push_expected();
        tick(bus.gamemode, 1'b0);
        tick(bus.gamemode, 1'b0);
        tick(m_after, 1'b1);
    endtask

    // Monitor: immediate check on reset assertion, scoreboard pop each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (clk) begin
                #1;
                checks++;
                if (bus.obstacle_x !== 200'd0 || bus.obstacle_y !== 180'd0) begin
                    errors++;
                    $display("FAIL async_reset: x=%h y=%h required 0", bus.obstacle_x, bus.obstacle_y);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.obstacle_x !== e.x || bus.obstacle_y !== e.y) begin
                    errors++;
                    $display("FAIL slots cyc %0d: x=%h y=%h required x=%h y=%h",
                             cyc, bus.obstacle_x, bus.obstacle_y, e.x, e.y);
                end
                if (e.dir == 1) begin
                    checks++;
                    if (bus.obstacle_x[19:0] !== {10'd608, 10'd639}) begin
                        errors++;
                        $display("FAIL first_spawn_x: got %h required %h",
                                 bus.obstacle_x[19:0], {10'd608, 10'd639});
                    end
                end else if (e.dir == 2) begin
                    checks++;
                    if (bus.obstacle_x !== 200'd0 || bus.obstacle_y !== 180'd0) begin
                        errors++;
                        $display("FAIL mode00_clear: x=%h y=%h required 0",
                                 bus.obstacle_x, bus.obstacle_y);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;
        int r;
        bus.gamemode = 2'b01;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset(2'b01);
        run(2'b01, 12);
        exp_q[$].dir = 1;

        run(2'b01, $urandom_range(40, 5));
        run(2'b10, 50);
        run(2'b01, 1000);

        for (int s = 0; s < 25; s++) begin
            r = $urandom_range(99, 0);
            n = $urandom_range(60, 1);
            if (r < 5)       run(2'b00, n);
            else if (r < 10) apply_reset(2'b01);
            else if (r < 70) run(2'b01, n * 4);
            else if (r < 85) run(2'b10, n);
            else             run(2'b11, n);
        end

        run(2'b01, 200);
        run(2'b11, 20);
        tick(2'b00, 1'b1);
        tick(2'b00, 1'b1);
        exp_q[$].dir = 2;
        run(2'b01, 20);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
